delay_align_sched: RTL and testbench

- Sequences automatic bit alignment across N_LANES delay_ctrl instances, one lane at a time. Per lane: arms auto mode, waits for alignment to finish, checks the eye width, and retries or gives up.
- Sits between the slow-control register block and the per-lane delay_ctrl array.
- Locked lanes are left in auto (tracking) mode. Failed lanes are returned to manual mode.

---
 rtl/delay_sched_pkg.sv | 22 ++
 rtl/delay_align_sched_if.sv | 24 ++
 rtl/prio_enc_lsb.sv | 23 ++
 rtl/delay_align_sched.sv | 190 +++++++++++++++++++
 tb/tb_delay_align_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and constants for the lane alignment scheduler.
package delay_sched_pkg;

    // Width of one lane's eye_width field.
    localparam int EYE_W = 6;

    // Default number of cycles a lane is held in manual mode before re-arming.
    localparam int RELEASE_CYC_DEF = 4;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RELEASE,
        ARM,
        WAIT_DROP,
        WAIT_READY,
        EVAL,
        DONE
    } state_e;

endpackage

// File: rtl/delay_align_sched_if.sv
// Lane-side bus between the scheduler and the per-lane delay_ctrl array.
interface delay_align_sched_if
    import delay_sched_pkg::*;
#(
    parameter int N_LANES = 8
) ();

    logic [N_LANES-1:0]       lane_delay_mode;
    logic [N_LANES-1:0]       lane_delay_ready;
    logic [EYE_W*N_LANES-1:0] lane_eye_width;

    modport master (
        output lane_delay_mode,
        input  lane_delay_ready,
        input  lane_eye_width
    );

    modport slave (
        input  lane_delay_mode,
        output lane_delay_ready,
        output lane_eye_width
    );

endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc_lsb #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_align_sched.sv
// Walks enabled lanes in ascending order, arming auto alignment on each,
// judging the resulting eye, and retrying or giving up per lane.
module delay_align_sched
    import delay_sched_pkg::*;
#(
    parameter  int N_LANES     = 8,
    parameter  int TIMEOUT_W   = 24,
    parameter  int MAX_RETRY   = 3,
    parameter  int RELEASE_CYC = RELEASE_CYC_DEF,
    localparam int LANE_W      = (N_LANES > 1) ? $clog2(N_LANES) : 1,
    localparam int RETRY_W     = $clog2(MAX_RETRY + 1),
    localparam int REL_W       = $clog2(RELEASE_CYC + 1)
) (
    input  logic                     clk160,
    input  logic                     rstb,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_LANES-1:0]       lane_enable,
    input  logic [EYE_W-1:0]         min_eye,
    input  logic [TIMEOUT_W-1:0]     timeout_value,
    delay_align_sched_if.master      lanes,
    output logic [N_LANES-1:0]       lane_locked,
    output logic [N_LANES-1:0]       lane_failed,
    output logic [EYE_W*N_LANES-1:0] eye_width_capt,
    output logic [LANE_W-1:0]        cur_lane,
    output logic                     busy,
    output logic                     done
);

    state_e                   state_q, state_d;
    logic                     start_d_q;
    logic [N_LANES-1:0]       pending_q, pending_d;
    logic [LANE_W-1:0]        cur_q, cur_d;
    logic [RETRY_W-1:0]       retry_q, retry_d;
    logic [TIMEOUT_W-1:0]     timer_q, timer_d;
    logic [REL_W-1:0]         rel_q, rel_d;
    logic [N_LANES-1:0]       mode_q, mode_d;
    logic [N_LANES-1:0]       locked_q, locked_d;
    logic [N_LANES-1:0]       failed_q, failed_d;
    logic [EYE_W*N_LANES-1:0] capt_q, capt_d;

    logic                     enc_valid;
    logic [LANE_W-1:0]        enc_idx;
    logic                     fail_attempt;
    logic [EYE_W-1:0]         eye_cur;
    logic [TIMEOUT_W-1:0]     timer_inc;

    prio_enc_lsb #(.N(N_LANES)) u_enc (
        .req_i  (pending_q),
        .idx_o  (enc_idx),
        .valid_o(enc_valid)
    );

    assign eye_cur   = lanes.lane_eye_width[cur_q*EYE_W +: EYE_W];
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_W'(1);

    // Next-state and per-lane bookkeeping; abort overrides any other transition.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cur_d        = cur_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        rel_d        = rel_q;
        mode_d       = mode_q;
        locked_d     = locked_q;
        failed_d     = failed_q;
        capt_d       = capt_q;
        fail_attempt = 1'b0;

        if (abort && state_q != IDLE && state_q != DONE) begin
            // A locked lane keeps tracking; anything mid-attempt goes back to manual.
            if (!locked_q[cur_q]) mode_d[cur_q] = 1'b0;
            pending_d = '0;
            state_d   = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !start_d_q) begin
                        pending_d = lane_enable;
                        locked_d  = locked_q & ~lane_enable;
                        failed_d  = failed_q & ~lane_enable;
                        mode_d    = mode_q & ~lane_enable;
                        state_d   = SELECT;
                    end
                end
                SELECT: begin
                    if (!enc_valid) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = enc_idx;
                        retry_d = '0;
                        rel_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    mode_d[cur_q] = 1'b0;
                    if (rel_q == REL_W'(RELEASE_CYC - 1)) state_d = ARM;
                    else                                  rel_d   = rel_q + REL_W'(1);
                end
                ARM: begin
                    mode_d[cur_q] = 1'b1;
                    timer_d       = '0;
                    state_d       = WAIT_DROP;
                end
                WAIT_DROP: begin
                    // Timeout is checked first so it wins over a same-cycle drop.
                    if (timer_q == timeout_value) begin
                        fail_attempt = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                        if (!lanes.lane_delay_ready[cur_q]) state_d = WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (timer_q == timeout_value) begin
                        fail_attempt = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                        if (lanes.lane_delay_ready[cur_q]) state_d = EVAL;
                    end
                end
                EVAL: begin
                    capt_d[cur_q*EYE_W +: EYE_W] = eye_cur;
                    if (eye_cur >= min_eye) begin
                        locked_d[cur_q]  = 1'b1;
                        pending_d[cur_q] = 1'b0;
                        state_d          = SELECT;
                    end else begin
                        fail_attempt = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (fail_attempt) begin
                retry_d = retry_q + RETRY_W'(1);
                if (int'(retry_q) + 1 < MAX_RETRY) begin
                    rel_d   = '0;
                    state_d = RELEASE;
                end else begin
                    failed_d[cur_q]  = 1'b1;
                    mode_d[cur_q]    = 1'b0;
                    pending_d[cur_q] = 1'b0;
                    state_d          = SELECT;
                end
            end
        end
    end

    // State and bookkeeping registers; reset returns every lane to manual mode.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            start_d_q <= 1'b0;
            pending_q <= '0;
            cur_q     <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            rel_q     <= '0;
            mode_q    <= '0;
            locked_q  <= '0;
            failed_q  <= '0;
            capt_q    <= '0;
        end else begin
            state_q   <= state_d;
            start_d_q <= start;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            rel_q     <= rel_d;
            mode_q    <= mode_d;
            locked_q  <= locked_d;
            failed_q  <= failed_d;
            capt_q    <= capt_d;
        end
    end

    assign lanes.lane_delay_mode = mode_q;
    assign lane_locked           = locked_q;
    assign lane_failed           = failed_q;
    assign eye_width_capt        = capt_q;
    assign cur_lane              = cur_q;
    assign busy                  = (state_q != IDLE);
    assign done                  = (state_q == DONE);

endmodule

// File: tb/tb_delay_align_sched.sv
// Bench for delay_align_sched: behavioural lane models, a per-lane outcome
// scoreboard, a table of sweep scenarios and hand-written abort/reset/empty runs.
module tb_delay_align_sched;

    localparam int N  = 8;
    localparam int MR = 3;

    logic        clk160 = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  lane_enable = '0;
    logic [5:0]  min_eye = '0;
    logic [23:0] timeout_value = '0;
    logic [7:0]  lane_locked, lane_failed;
    logic [47:0] eye_width_capt;
    logic [2:0]  cur_lane;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    delay_align_sched_if #(.N_LANES(N)) lif ();

    delay_align_sched #(.N_LANES(N), .TIMEOUT_W(24), .MAX_RETRY(MR), .RELEASE_CYC(4)) dut (
        .clk160(clk160), .rstb(rstb), .start(start), .abort(abort),
        .lane_enable(lane_enable), .min_eye(min_eye), .timeout_value(timeout_value),
        .lanes(lif), .lane_locked(lane_locked), .lane_failed(lane_failed),
        .eye_width_capt(eye_width_capt), .cur_lane(cur_lane), .busy(busy), .done(done)
    );

    always #5 clk160 = ~clk160;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- lane models ----------------
    logic [7:0]  rdy = '0;
    logic [47:0] eyes = '0;
    logic [5:0]  eye_cfg [N][3];
    logic [7:0]  never_mask = '0;
    int          rdy_dly = 100;
    int          cnt [N];
    bit          active [N];
    bit          prev_mode [N];
    int          attempts [N];
    int          low_cnt [N];
    int          last_gap [N];

    assign lif.lane_delay_ready = rdy;
    assign lif.lane_eye_width   = eyes;

    always @(posedge clk160) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rstb) begin
                rdy[i] = 1'b0; eyes[6*i +: 6] = '0; active[i] = 0;
                prev_mode[i] = 0; low_cnt[i] = 0; cnt[i] = 0;
            end else begin
                if (lif.lane_delay_mode[i] && !prev_mode[i]) begin
                    attempts[i]++;
                    last_gap[i] = low_cnt[i];
                    low_cnt[i] = 0; cnt[i] = 0; active[i] = 1;
                end else if (lif.lane_delay_mode[i] && active[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) rdy[i] = 1'b0;
                    if (cnt[i] == 2 + rdy_dly && !never_mask[i]) begin
                        rdy[i] = 1'b1;
                        eyes[6*i +: 6] = eye_cfg[i][(attempts[i] > 3) ? 2 : attempts[i] - 1];
                        active[i] = 0;
                    end
                end
                if (!lif.lane_delay_mode[i]) begin
                    low_cnt[i]++;
                    active[i] = 0;
                end
                prev_mode[i] = lif.lane_delay_mode[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         lane;
        bit         locked;
        bit         chk_eye;
        logic [5:0] eye;
        int         attempts;
    } exp_t;
    exp_t exp_q[$];
    logic [7:0] prev_flags = '0;

    always @(negedge clk160) begin
        logic [7:0] flags, nw;
        exp_t e;
        flags = lane_locked | lane_failed;
        nw = flags & ~prev_flags;
        if (rstb) begin
            for (int j = 0; j < N; j++) begin
                if (nw[j]) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_lane", j, 99);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_lane_order", j, e.lane);
                        check("sb_outcome_locked", lane_locked[j], e.locked);
                        check("sb_attempts", attempts[j], e.attempts);
                        if (e.chk_eye) check("sb_eye_capt", eye_width_capt[6*j +: 6], e.eye);
                    end
                end
            end
        end
        prev_flags = flags;
    end

    task automatic push_expected(input logic [7:0] en, input logic [5:0] me, input logic [23:0] tmo);
        exp_t e;
        for (int l = 0; l < N; l++) begin
            if (en[l]) begin
                e.lane = l; e.locked = 0; e.chk_eye = 0; e.eye = '0; e.attempts = MR;
                for (int a = 0; a < MR; a++) begin
                    if (!never_mask[l] && tmo != 0) begin
                        e.eye = eye_cfg[l][a];
                        e.chk_eye = 1;
                        if (eye_cfg[l][a] >= me) begin
                            e.locked = 1; e.attempts = a + 1;
                            break;
                        end
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_cfg(input logic [7:0] never, input logic [17:0] eye3);
        never_mask = never;
        for (int l = 0; l < N; l++)
            for (int a = 0; a < 3; a++)
                eye_cfg[l][a] = (l == 3) ? eye3[6*a +: 6] : 6'd20;
    endtask

    // Drives inputs, predicts outcomes, and returns just after the trigger edge.
    task automatic begin_sweep(input logic [7:0] en, input logic [5:0] me, input logic [23:0] tmo);
        @(negedge clk160);
        lane_enable = en; min_eye = me; timeout_value = tmo;
        for (int l = 0; l < N; l++) if (en[l]) attempts[l] = 0;
        push_expected(en, me, tmo);
        @(posedge clk160); #1 start = 1'b1;
        @(posedge clk160); #1 start = 1'b0;
    endtask

    task automatic run_sweep(input logic [7:0] en, input logic [5:0] me, input logic [23:0] tmo,
                             output int done_cnt, output int busy_cyc, output int first_done,
                             output int toggles);
        logic [7:0] pm;
        bit timed_out;
        begin_sweep(en, me, tmo);
        pm = lif.lane_delay_mode;
        done_cnt = 0; busy_cyc = 0; first_done = -1; toggles = 0; timed_out = 1;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk160);
            if (lif.lane_delay_mode != pm) toggles++;
            pm = lif.lane_delay_mode;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            if (!busy) begin
                timed_out = 0;
                break;
            end
        end
        check("sweep_timeout", timed_out, 0);
    endtask

    typedef struct {
        logic [7:0]  en;
        logic [5:0]  me;
        logic [23:0] tmo;
        logic [7:0]  never;
        logic [17:0] eye3;
        logic [7:0]  exp_locked, exp_failed, exp_mode;
        int          gap_lane, exp_gap;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int dc, bc, fd, tg, found;

        vecs[0] = '{8'hFF, 6'd8,  24'd5000, 8'h00, {6'd20, 6'd20, 6'd20}, 8'hFF, 8'h00, 8'hFF, -1, 0};
        vecs[1] = '{8'hFF, 6'd8,  24'd5000, 8'h00, {6'd12, 6'd5,  6'd5 }, 8'hFF, 8'h00, 8'hFF,  3, 4};
        vecs[2] = '{8'hFF, 6'd8,  24'd1000, 8'h20, {6'd20, 6'd20, 6'd20}, 8'hDF, 8'h20, 8'hDF, -1, 0};
        vecs[3] = '{8'h0F, 6'd25, 24'd5000, 8'h00, {6'd20, 6'd20, 6'd20}, 8'hD0, 8'h2F, 8'hD0, -1, 0};
        vecs[4] = '{8'hFF, 6'd20, 24'd5000, 8'h00, {6'd20, 6'd20, 6'd20}, 8'hFF, 8'h00, 8'hFF, -1, 0};
        vecs[5] = '{8'h01, 6'd8,  24'd0,    8'h00, {6'd20, 6'd20, 6'd20}, 8'hFE, 8'h01, 8'hFE, -1, 0};

        // Reset values
        rstb = 1'b0;
        repeat (3) @(posedge clk160);
        @(negedge clk160);
        check("rst_mode", lif.lane_delay_mode, 0);
        check("rst_locked", lane_locked, 0);
        check("rst_failed", lane_failed, 0);
        check("rst_capt", eye_width_capt, 0);
        check("rst_cur_lane", cur_lane, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rstb = 1'b1;

        // Table-driven sweeps
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].never, vecs[v].eye3);
            run_sweep(vecs[v].en, vecs[v].me, vecs[v].tmo, dc, bc, fd, tg);
            check($sformatf("v%0d_done_pulses", v), dc, 1);
            check($sformatf("v%0d_locked", v), lane_locked, vecs[v].exp_locked);
            check($sformatf("v%0d_failed", v), lane_failed, vecs[v].exp_failed);
            check($sformatf("v%0d_mode", v), lif.lane_delay_mode, vecs[v].exp_mode);
            check($sformatf("v%0d_sb_drained", v), exp_q.size(), 0);
            if (vecs[v].gap_lane >= 0)
                check($sformatf("v%0d_release_gap", v), last_gap[vecs[v].gap_lane], vecs[v].exp_gap);
        end

        // Empty sweep: only SELECT and DONE, no lane is touched
        run_sweep(8'h00, 6'd8, 24'd5000, dc, bc, fd, tg);
        check("empty_done_pulses", dc, 1);
        check("empty_done_cycle", fd, 2);
        check("empty_busy_cycles", bc, 2);
        check("empty_mode_toggles", tg, 0);
        check("empty_locked", lane_locked, 8'hFE);
        check("empty_mode", lif.lane_delay_mode, 8'hFE);

        // Abort while lane 2 waits for ready
        set_cfg(8'h00, {6'd20, 6'd20, 6'd20});
        begin_sweep(8'hFF, 6'd8, 24'd5000);
        found = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk160);
            if (cur_lane == 3'd2 && lif.lane_delay_mode[2] && !lif.lane_delay_ready[2]) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_lane2", found, 1);
        @(posedge clk160); #1 abort = 1'b1;
        @(posedge clk160); #1 abort = 1'b0;
        @(negedge clk160);
        check("abort_done", done, 1);
        check("abort_mode", lif.lane_delay_mode, 8'h03);
        check("abort_locked", lane_locked, 8'h03);
        check("abort_failed", lane_failed, 8'h00);
        @(negedge clk160);
        check("abort_busy_fall", busy, 0);
        check("abort_done_one_cycle", done, 0);
        check("abort_sb_left", exp_q.size(), 6);
        exp_q.delete();

        // Asynchronous reset while lane 4 waits for the stale ready to drop
        begin_sweep(8'hFF, 6'd8, 24'd5000);
        found = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk160);
            if (cur_lane == 3'd4 && lif.lane_delay_mode[4] && lif.lane_delay_ready[4]) begin
                found = 1;
                break;
            end
        end
        check("reset_reach_lane4", found, 1);
        #2 rstb = 1'b0;
        #1;
        check("midrst_mode", lif.lane_delay_mode, 0);
        check("midrst_locked", lane_locked, 0);
        check("midrst_failed", lane_failed, 0);
        check("midrst_capt", eye_width_capt, 0);
        check("midrst_cur_lane", cur_lane, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sb_left", exp_q.size(), 4);
        exp_q.delete();
        repeat (2) @(posedge clk160);
        @(negedge clk160);
        rstb = 1'b1;

        run_sweep(8'hFF, 6'd8, 24'd5000, dc, bc, fd, tg);
        check("postrst_done_pulses", dc, 1);
        check("postrst_locked", lane_locked, 8'hFF);
        check("postrst_failed", lane_failed, 8'h00);
        check("postrst_mode", lif.lane_delay_mode, 8'hFF);
        check("postrst_sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
